// File: rtl/program_loader_if.sv
// Byte-stream and instruction-store bundle for program_loader.
//   start        load request pulse (environment -> loader)
//   in_data      stream byte
//   in_valid     in_data valid
//   in_last      marks the final byte of the program
//   in_ready     loader accepts a byte this cycle (loader -> environment)
//   wr_en        instruction-store write strobe
//   wr_addr      write address
//   wr_data      write data
//   load_done    store fully written, held until the next start
//   err_partial  sticky: last byte arrived mid-word
//   err_overflow sticky: stream longer than the store
// Modport master is the loader, which masters the write bus and the stream ready.
// Modport slave is the environment: stream source, instruction store and core.
interface program_loader_if #(
    parameter int unsigned BYTE_WIDTH  = 8,
    parameter int unsigned INSTR_WIDTH = 24,
    parameter int unsigned ADDR_WIDTH  = 4
);
    logic                   start;
    logic [BYTE_WIDTH-1:0]  in_data;
    logic                   in_valid;
    logic                   in_last;
    logic                   in_ready;
    logic                   wr_en;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [INSTR_WIDTH-1:0] wr_data;
    logic                   load_done;
    logic                   err_partial;
    logic                   err_overflow;

    modport master (
        input  start, in_data, in_valid, in_last,
        output in_ready, wr_en, wr_addr, wr_data, load_done, err_partial, err_overflow
    );

    modport slave (
        output start, in_data, in_valid, in_last,
        input  in_ready, wr_en, wr_addr, wr_data, load_done, err_partial, err_overflow
    );
endinterface

// File: rtl/program_loader.sv
// Loads the accelerator's instruction store from a byte stream.
// Bytes are packed three at a time, MSB first, into instruction words that are written
// from address 0 upwards; unused slots are filled with HALT words, then load_done rises.
// INSTR_WIDTH must equal 3*BYTE_WIDTH.
// Ports:
//   clk  rising-edge clock
//   rst  synchronous active-low reset
//   bus  program_loader_if.master (stream in, store write bus, status out)
module program_loader #(
    parameter int unsigned NUM_INSTRUCTIONS = 16,
    parameter int unsigned INSTR_WIDTH      = 24,
    parameter int unsigned BYTE_WIDTH       = 8,
    parameter int unsigned HALT_OPCODE      = 10
) (
    input logic              clk,
    input logic              rst,
    program_loader_if.master bus
);
    localparam int unsigned AddrWidth = $clog2(NUM_INSTRUCTIONS);
    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NUM_INSTRUCTIONS - 1);
    // Opcode occupies the top 6 bits of a pad word, everything else zero.
    localparam logic [INSTR_WIDTH-1:0] HaltWord = INSTR_WIDTH'(HALT_OPCODE) << (INSTR_WIDTH - 6);

    typedef enum logic [2:0] {StIdle, StLoad, StDrain, StPad, StDone} state_e;

    state_e                 state_q, state_d;
    logic [1:0]             byte_cnt_q, byte_cnt_d;
    logic [AddrWidth-1:0]   idx_q, idx_d;
    logic [INSTR_WIDTH-1:0] asm_q, asm_d;
    logic                   wr_en_q, wr_en_d;
    logic [AddrWidth-1:0]   wr_addr_q, wr_addr_d;
    logic [INSTR_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                   load_done_q, load_done_d;
    logic                   err_partial_q, err_partial_d;
    logic                   err_overflow_q, err_overflow_d;

    logic                   in_ready;
    logic                   accept;
    logic [INSTR_WIDTH-1:0] word;

    assign in_ready = (state_q == StLoad) || (state_q == StDrain);
    assign accept   = bus.in_valid && in_ready;

    // Word as it would look with the incoming byte merged in; low bytes not yet
    // received are zero, which is exactly the fill needed when in_last cuts a word short.
    always_comb begin
        unique case (byte_cnt_q)
            2'd0:    word = {bus.in_data, {(2*BYTE_WIDTH){1'b0}}};
            2'd1:    word = {asm_q[INSTR_WIDTH-1 -: BYTE_WIDTH], bus.in_data, {BYTE_WIDTH{1'b0}}};
            default: word = {asm_q[INSTR_WIDTH-1 -: 2*BYTE_WIDTH], bus.in_data};
        endcase
    end

    always_comb begin
        state_d        = state_q;
        byte_cnt_d     = byte_cnt_q;
        idx_d          = idx_q;
        asm_d          = asm_q;
        wr_en_d        = 1'b0;
        wr_addr_d      = wr_addr_q;
        wr_data_d      = wr_data_q;
        load_done_d    = load_done_q;
        err_partial_d  = err_partial_q;
        err_overflow_d = err_overflow_q;

        unique case (state_q)
            StIdle, StDone: begin
                // Entering DONE coincides with the final write; load_done follows a cycle later.
                if (state_q == StDone) begin
                    load_done_d = 1'b1;
                end
                if (bus.start) begin
                    state_d        = StLoad;
                    byte_cnt_d     = '0;
                    idx_d          = '0;
                    load_done_d    = 1'b0;
                    err_partial_d  = 1'b0;
                    err_overflow_d = 1'b0;
                end
            end
            StLoad: begin
                if (accept) begin
                    asm_d = word;
                    if (byte_cnt_q == 2'd2 || bus.in_last) begin
                        wr_en_d    = 1'b1;
                        wr_addr_d  = idx_q;
                        wr_data_d  = word;
                        byte_cnt_d = '0;
                        if (bus.in_last && byte_cnt_q != 2'd2) begin
                            err_partial_d = 1'b1;
                        end
                        // Index saturates at the last slot rather than wrapping.
                        if (idx_q == LastIdx) begin
                            state_d = bus.in_last ? StDone : StDrain;
                        end else begin
                            idx_d = idx_q + 1'b1;
                            if (bus.in_last) begin
                                state_d = StPad;
                            end
                        end
                    end else begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            StDrain: begin
                if (accept) begin
                    err_overflow_d = 1'b1;
                    if (bus.in_last) begin
                        state_d     = StDone;
                        load_done_d = 1'b1;
                    end
                end
            end
            StPad: begin
                wr_en_d   = 1'b1;
                wr_addr_d = idx_q;
                wr_data_d = HaltWord;
                if (idx_q == LastIdx) begin
                    state_d = StDone;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= StIdle;
            byte_cnt_q     <= '0;
            idx_q          <= '0;
            asm_q          <= '0;
            wr_en_q        <= 1'b0;
            wr_addr_q      <= '0;
            wr_data_q      <= '0;
            load_done_q    <= 1'b0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            byte_cnt_q     <= byte_cnt_d;
            idx_q          <= idx_d;
            asm_q          <= asm_d;
            wr_en_q        <= wr_en_d;
            wr_addr_q      <= wr_addr_d;
            wr_data_q      <= wr_data_d;
            load_done_q    <= load_done_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.wr_en        = wr_en_q;
    assign bus.wr_addr      = wr_addr_q;
    assign bus.wr_data      = wr_data_q;
    assign bus.load_done    = load_done_q;
    assign bus.err_partial  = err_partial_q;
    assign bus.err_overflow = err_overflow_q;
endmodule
